// File: rtl/sipo_pkg.sv
// Shared types and constants for the SIPO deframer: FSM encoding and default sizing.
package sipo_pkg;

    localparam int unsigned WIDTH_DEF = 8;
    localparam int unsigned CNT_W     = $clog2(WIDTH_DEF + 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/sipo_if.sv
// Serial input stream plus valid/ready word output of the deframer.
interface sipo_if import sipo_pkg::*; #(
    parameter int unsigned WIDTH = WIDTH_DEF
);

    logic             sin;
    logic             sin_vld;
    logic             sin_sof;
    logic [WIDTH-1:0] dout;
    logic             dout_vld;
    logic             dout_rdy;
    logic             frame_err;
    logic             overrun;

    // Driver/consumer side: feeds bits, accepts words
    modport master (
        output sin, sin_vld, sin_sof, dout_rdy,
        input  dout, dout_vld, frame_err, overrun
    );

    // Deframer side
    modport slave (
        input  sin, sin_vld, sin_sof, dout_rdy,
        output dout, dout_vld, frame_err, overrun
    );

endinterface

// File: rtl/sipo_out_reg.sv
// One-entry valid/ready holding register; a completed word arriving while the
// entry is full and not being drained is dropped and flagged in sticky overrun.
module sipo_out_reg #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] dout,
    output logic             dout_vld,
    input  logic             dout_rdy,
    output logic             overrun
);

    always_ff @(posedge clk) begin
        if (reset) begin
            dout     <= '0;
            dout_vld <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            // A drain in the same cycle frees the entry for the new word
            if (load && (!dout_vld || dout_rdy)) begin
                dout     <= load_data;
                dout_vld <= 1'b1;
            end else if (dout_vld && dout_rdy) begin
                dout_vld <= 1'b0;
            end
            if (load && dout_vld && !dout_rdy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sipo_deframer.sv
// Serial-in/parallel-out receiver: aligns on sof, assembles WIDTH-bit words and
// hands them to a valid/ready output register, flagging restarts and drops.
module sipo_deframer import sipo_pkg::*; #(
    parameter int unsigned WIDTH     = WIDTH_DEF,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic  clk,
    input  logic  reset,
    sipo_if.slave bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             ferr_q, ferr_d;
    logic [WIDTH-1:0] shift_c;
    logic [WIDTH-1:0] first_c;
    logic             load_c;
    logic [WIDTH-1:0] dout_q;
    logic             vld_q;
    logic             ovr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            ferr_q  <= ferr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        ferr_d  = 1'b0;
        load_c  = 1'b0;
        // Bit order decides which end receives the new bit
        shift_c = MSB_FIRST ? {shreg_q[WIDTH-2:0], bus.sin} : {bus.sin, shreg_q[WIDTH-1:1]};
        first_c = MSB_FIRST ? WIDTH'(bus.sin) : {bus.sin, {(WIDTH-1){1'b0}}};
        case (state_q)
            ST_IDLE: begin
                if (bus.sin_vld && bus.sin_sof) begin
                    shreg_d = first_c;
                    cnt_d   = CW'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (bus.sin_vld) begin
                    if (bus.sin_sof) begin
                        // Restart: discard the partial word, this bit opens a new one
                        ferr_d  = 1'b1;
                        shreg_d = first_c;
                        cnt_d   = CW'(1);
                    end else if (cnt_q == CW'(WIDTH - 1)) begin
                        load_c  = 1'b1;
                        shreg_d = shift_c;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        shreg_d = shift_c;
                        cnt_d   = cnt_q + CW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    sipo_out_reg #(
        .WIDTH (WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (load_c),
        .load_data (shift_c),
        .dout      (dout_q),
        .dout_vld  (vld_q),
        .dout_rdy  (bus.dout_rdy),
        .overrun   (ovr_q)
    );

    assign bus.dout      = dout_q;
    assign bus.dout_vld  = vld_q;
    assign bus.overrun   = ovr_q;
    assign bus.frame_err = ferr_q;

endmodule
